// File: rtl/mc_control_if.sv
// Instruction/memory control bundle between the sequencer and its datapath.
// slave modport: the controller (samples requests, drives strobes/selects).
// master modport: the driving side (offers instructions, acks memory).
interface mc_control_if #(
  parameter int OP_W = 3
);
  // Offer side
  logic            instr_valid_i;
  logic [OP_W-1:0] op_i;
  logic            mem_ack_i;
  logic            fault_clr_i;
  // Control side
  logic            instr_ready_o;
  logic [1:0]      wb_sel_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            imm_en_o;
  logic            jal_en_o;
  logic            jalr_en_o;
  logic            rf_we_o;
  logic            pc_we_o;
  logic            busy_o;
  logic            fault_o;

  modport slave (
    input  instr_valid_i, op_i, mem_ack_i, fault_clr_i,
    output instr_ready_o, wb_sel_o, mem_read_o, mem_write_o,
           imm_en_o, jal_en_o, jalr_en_o, rf_we_o, pc_we_o, busy_o, fault_o
  );

  modport master (
    output instr_valid_i, op_i, mem_ack_i, fault_clr_i,
    input  instr_ready_o, wb_sel_o, mem_read_o, mem_write_o,
           imm_en_o, jal_en_o, jalr_en_o, rf_we_o, pc_we_o, busy_o, fault_o
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle instruction sequencer: IDLE -> DECODE -> EXEC -> [MEM] -> [WB] -> IDLE.
// Latency: R/I/J/JR 4 cycles, B 3, L/S 4 + MEM wait cycles; accepts only in IDLE.
// Backpressure: instr_ready_o high only in IDLE; MEM stalls until mem_ack_i.
//
// Ports: clk_i, rst_ni (async active-low), mc (mc_control_if.slave) carrying
// the instruction handshake, memory request/ack, fault clear and all
// datapath selects/strobes. Every output is Moore-decoded from r_state and
// the latched opcode r_op, so no input reaches an output combinationally.
//
// Optional build macro MC_CONTROL_TIMEOUT_EN: adds an 8-bit MEM wait counter
// that faults after MEM_TIMEOUT cycles without mem_ack_i. Without it the MEM
// state waits indefinitely and only an illegal opcode reaches FAULT.
module mc_control #(
  parameter int OP_W        = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mc_control_if.slave  mc
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [2:0] OP_R  = 3'd0;
  localparam logic [2:0] OP_I  = 3'd1;
  localparam logic [2:0] OP_L  = 3'd2;
  localparam logic [2:0] OP_S  = 3'd3;
  localparam logic [2:0] OP_B  = 3'd4;
  localparam logic [2:0] OP_J  = 3'd5;
  localparam logic [2:0] OP_JR = 3'd6;

  localparam logic [1:0] WB_ALU          = 2'd0;
  localparam logic [1:0] WB_MEM          = 2'd1;
  localparam logic [1:0] WB_PC_PLUS_FOUR = 2'd2;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [OP_W-1:0] r_op;
  logic [2:0]      w_op_lo;
  logic            w_illegal;
  logic            w_flags_on;
  logic            w_tmo_hit;

  assign w_op_lo   = r_op[2:0];
  // Any bit above the 3-bit class field, or class 7, is not an instruction.
  assign w_illegal = ((r_op >> 3) != '0) || (w_op_lo == 3'd7);
  // Decode flags live from DECODE through WB; IDLE and FAULT force them low.
  assign w_flags_on = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                      (r_state == S_MEM)    || (r_state == S_WB);

`ifdef MC_CONTROL_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;

  // Held at zero outside MEM so every MEM visit starts a fresh count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_state != S_MEM) begin
      r_tmo_cnt <= 8'd0;
    end else if (!mc.mem_ack_i) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  // The cycle in which the count would reach MEM_TIMEOUT is the last MEM cycle.
  assign w_tmo_hit = (r_state == S_MEM) && !mc.mem_ack_i &&
                     (r_tmo_cnt == 8'(MEM_TIMEOUT - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State and opcode registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && mc.instr_valid_i) begin
        r_op <= mc.op_i;
      end
    end
  end

  // Next state and Moore output decode.
  always_comb begin
    w_state_nxt      = r_state;
    mc.instr_ready_o = 1'b0;
    mc.busy_o        = 1'b0;
    mc.fault_o       = 1'b0;
    mc.wb_sel_o      = WB_ALU;
    mc.mem_read_o    = 1'b0;
    mc.mem_write_o   = 1'b0;
    mc.imm_en_o      = 1'b0;
    mc.jal_en_o      = 1'b0;
    mc.jalr_en_o     = 1'b0;
    mc.rf_we_o       = 1'b0;
    mc.pc_we_o       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        mc.instr_ready_o = 1'b1;
        if (mc.instr_valid_i) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_illegal) begin
          w_state_nxt = S_FAULT;
        end else begin
          case (w_op_lo)
            OP_L, OP_S: w_state_nxt = S_MEM;
            OP_B:       w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_WB;
          endcase
        end
      end
      S_MEM: begin
        // Stores also pass through WB: it supplies their pc_we_o pulse
        // without writing the register file.
        if (mc.mem_ack_i) begin
          w_state_nxt = S_WB;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_WB: begin
        w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        mc.fault_o = 1'b1;
        if (mc.fault_clr_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    mc.busy_o = (r_state != S_IDLE);

    if (w_flags_on && !w_illegal) begin
      case (w_op_lo)
        OP_I:  mc.imm_en_o = 1'b1;
        OP_L:  mc.wb_sel_o = WB_MEM;
        OP_J:  begin
          mc.jal_en_o = 1'b1;
          mc.wb_sel_o = WB_PC_PLUS_FOUR;
        end
        OP_JR: begin
          mc.jalr_en_o = 1'b1;
          mc.wb_sel_o  = WB_PC_PLUS_FOUR;
        end
        default: ;
      endcase

      mc.mem_read_o  = (r_state == S_MEM) && (w_op_lo == OP_L);
      mc.mem_write_o = (r_state == S_MEM) && (w_op_lo == OP_S);
      mc.rf_we_o     = (r_state == S_WB) && (w_op_lo != OP_S);
      // Branches resolve in EXEC and return straight to IDLE.
      mc.pc_we_o     = (r_state == S_WB) ||
                       ((r_state == S_EXEC) && (w_op_lo == OP_B));
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed cases followed by random
// instruction streams, checked every cycle against a transaction-level
// model that expands each instruction into its expected output trace.
module tb_mc_control;

  localparam int OP_W  = 4;
  localparam int MEM_T = 4;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       fault;
    logic [1:0] wb;
    logic       rd;
    logic       wr;
    logic       imm;
    logic       jal;
    logic       jalr;
    logic       rf;
    logic       pc;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  outs_t exp_q[$];
  int    ack_q[$];   // 0: drive 0, 1: drive 1, 2: random (ignored by DUT)
  int    clr_q[$];

  mc_control_if #(.OP_W(OP_W)) mc ();

  mc_control #(.OP_W(OP_W), .MEM_TIMEOUT(MEM_T)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .mc     (mc)
  );

  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t o;
    o.ready = mc.instr_ready_o;
    o.busy  = mc.busy_o;
    o.fault = mc.fault_o;
    o.wb    = mc.wb_sel_o;
    o.rd    = mc.mem_read_o;
    o.wr    = mc.mem_write_o;
    o.imm   = mc.imm_en_o;
    o.jal   = mc.jal_en_o;
    o.jalr  = mc.jalr_en_o;
    o.rf    = mc.rf_we_o;
    o.pc    = mc.pc_we_o;
    return o;
  endfunction

  function automatic outs_t idle_outs();
    outs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  // Decode table: flags held while an instruction is in flight.
  function automatic outs_t flags(int op);
    outs_t o = '0;
    o.busy = 1'b1;
    case (op)
      1: o.imm = 1'b1;
      2: o.wb = 2'd1;
      5: begin o.jal = 1'b1; o.wb = 2'd2; end
      6: begin o.jalr = 1'b1; o.wb = 2'd2; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(outs_t o, int a, int c);
    exp_q.push_back(o);
    ack_q.push_back(a);
    clr_q.push_back(c);
  endtask

  task automatic push_fault(int f);
    outs_t o = '0;
    o.busy  = 1'b1;
    o.fault = 1'b1;
    for (int i = 0; i < f; i++) push(o, 2, (i == f - 1) ? 1 : 0);
  endtask

  // Expected trace, one entry per cycle after the handshake edge.
  // k: MEM cycle in which ack arrives; f: FAULT cycles before clear.
  task automatic build(int op, int k, int f);
    outs_t fl = flags(op);
    outs_t o;
    int    n;
    bit    to;
    exp_q.delete(); ack_q.delete(); clr_q.delete();
    push(fl, 2, 2);                             // DECODE
    if (op > 6) begin
      push(fl, 2, 2);                           // EXEC
      push_fault(f);
    end else if (op == 4) begin
      o = fl; o.pc = 1'b1;
      push(o, 2, 2);                            // EXEC with branch PC write
    end else if (op == 2 || op == 3) begin
      push(fl, 2, 2);                           // EXEC
      n  = k;
      to = 1'b0;
`ifdef MC_CONTROL_TIMEOUT_EN
      if (k > MEM_T) begin n = MEM_T; to = 1'b1; end
`endif
      for (int i = 0; i < n; i++) begin
        o = fl;
        if (op == 2) o.rd = 1'b1; else o.wr = 1'b1;
        push(o, (!to && i == n - 1) ? 1 : 0, 2);
      end
      if (to) begin
        push_fault(f);
      end else begin
        o = fl; o.pc = 1'b1; o.rf = (op == 2);
        push(o, 2, 2);
      end
    end else begin
      push(fl, 2, 2);                           // EXEC
      o = fl; o.pc = 1'b1; o.rf = 1'b1;
      push(o, 2, 2);                            // WB
    end
    push(idle_outs(), 2, 2);
  endtask

  task automatic check(string tag, outs_t obs, outs_t expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  function automatic logic pick(int code);
    if (code == 2) return 1'($urandom_range(0, 1));
    return (code == 1);
  endfunction

  // Offers op now, then walks the expected trace (at most nsteps entries).
  task automatic run_instr(int op, int k, int f, int nsteps);
    int lim;
    build(op, k, f);
    lim = (nsteps < 0 || nsteps > exp_q.size()) ? exp_q.size() : nsteps;
    mc.instr_valid_i = 1'b1;
    mc.op_i          = OP_W'(op);
    for (int j = 0; j < lim; j++) begin
      @(negedge clk);
      mc.instr_valid_i = 1'b0;
      mc.op_i          = OP_W'($urandom);
      check($sformatf("op%0d_k%0d_c%0d", op, k, j + 1), sample(), exp_q[j]);
      mc.mem_ack_i   = pick(ack_q[j]);
      mc.fault_clr_i = pick(clr_q[j]);
    end
  endtask

  initial begin
    int op;
    mc.instr_valid_i = 1'b0;
    mc.op_i          = '0;
    mc.mem_ack_i     = 1'b0;
    mc.fault_clr_i   = 1'b0;

    #12;
    check("reset_state", sample(), idle_outs());
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: first edge after release accepts an R op.
    run_instr(0, 1, 1, -1);
    run_instr(1, 1, 1, -1);
    run_instr(2, 3, 1, -1);                // load, ack in third MEM cycle
    run_instr(3, 1, 1, -1);                // store, ack in first MEM cycle
    run_instr(4, 1, 1, -1);                // branch
    run_instr(6, 1, 1, -1);
    run_instr(7, 1, 2, -1);                // illegal class
    run_instr(9, 1, 1, -1);                // illegal: upper opcode bit set
    run_instr(2, MEM_T, 1, -1);            // ack exactly on the last allowed cycle
    run_instr(2, 105, 2, -1);              // long wait (timeout build: fault)

    // Asynchronous reset in the middle of a MEM wait.
    run_instr(2, 50, 1, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mem", sample(), idle_outs());
    mc.mem_ack_i   = 1'b0;
    mc.fault_clr_i = 1'b0;
    @(negedge clk);
    check("reset_held", sample(), idle_outs());
    rst_n = 1'b1;
    run_instr(5, 1, 1, -1);

    // Random instruction stream.
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 15))
                                       : int'($urandom_range(0, 6));
      run_instr(op, int'($urandom_range(1, 6)), int'($urandom_range(1, 3)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
